vbutton_conditioner: RTL and testbench
======================================

# vbutton_conditioner

Input-conditioning stage that sits directly upstream of the reaction-game device and feeds its `start`, `reset`, `btn2`, `btn1` and `btn0` inputs. It takes raw, asynchronous, bouncing push-button signals from the board and synchronises each one to `clk`. It debounces each channel with a per-channel counter and state machine. Per channel it produces a clean stable level and a single-cycle press pulse.

## Interface
- `CHANNELS`, default 5: number of independent button channels. Channel map is 4=start, 3=reset, 2=btn2, 1=btn1, 0=btn0.
- `DEBOUNCE_CYCLES`, default 500000 (10 ms at 50 MHz): consecutive stable cycles required to accept a change. Legal range is ≥ 1.
- `CNT_WIDTH`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width.
- `clk`  in  1  system clock.
- `async_nreset`  in  1  reset; asynchronous, active-low.
- `btn_raw`  in  CHANNELS  raw board buttons, asynchronous to `clk`.
- `btn_level`  out  CHANNELS  debounced level; 1 = pressed.
- `btn_pulse`  out  CHANNELS  one-cycle pulse on each accepted press.

## Operation
- **Synchroniser.** Each channel has a 2-flop synchroniser. Both flops reset to 0 (released). Only the second flop output, `sync`, is used downstream.
- **Per-channel FSM.** States are IDLE (stable released), PRESS_WAIT, PRESSED (stable pressed) and RELEASE_WAIT. Reset state is IDLE with counter 0.
- **IDLE:** `sync`=1 → PRESS_WAIT, counter loads 1.
- **PRESS_WAIT:**
  - `sync`=0 → IDLE, counter cleared (glitch rejected, no pulse).
  - `sync`=1 and counter==DEBOUNCE_CYCLES → PRESSED, counter cleared, pulse issued.
  - Otherwise counter increments.
- **PRESSED:** `sync`=0 → RELEASE_WAIT, counter loads 1.
- **RELEASE_WAIT:** mirror of PRESS_WAIT. Returns to PRESSED on `sync`=1, and goes to IDLE after the count completes. No pulse is issued on release.
- **Outputs are registered.**
  - `btn_level`=1 exactly while the state is PRESSED or RELEASE_WAIT.
  - `btn_pulse` is 1 for exactly one cycle, coincident with the first cycle of PRESSED.
- The counter never exceeds DEBOUNCE_CYCLES. It is cleared on every state change into IDLE or PRESSED, so no wrap-around can occur.
- Channels are fully independent. Simultaneous presses on several channels produce pulses on the same cycle if their timing is identical.
- A press held indefinitely produces exactly one pulse. Re-arming requires an accepted release (IDLE) first.
- Asserting `async_nreset` mid-count immediately forces all outputs to 0, all FSMs to IDLE and all counters to 0. A button held through reset release is seen as a new press and pulses after full debounce.

## Timing
- Reset values: `btn_level`=0 and `btn_pulse`=0 on all channels.
- Press latency: if raw high is first captured at edge 1 and stays high, `sync`=1 after edge 2, and `btn_level`/`btn_pulse` rise at edge DEBOUNCE_CYCLES+2. With DEBOUNCE_CYCLES=4 this is edge 6, and the pulse drops at edge 7.
- Release latency is the same: `btn_level` falls at edge DEBOUNCE_CYCLES+2 after the first captured low.
- Any raw bounce shorter than DEBOUNCE_CYCLES cycles (after synchronisation) produces no output change.
- The pulse is registered, so the downstream device's `INCR`/start decode sees it on the following edge.

## Configuration
- `VBUTTON_ACTIVE_LOW_EN`
  - **Defined:** `btn_raw` is inverted ahead of the synchroniser, because board keys read 0 when pressed. Synchroniser flops still reset to the released state, i.e. to 0 after inversion.
  - **Undefined:** `btn_raw` is used as-is, with 1 = pressed.
  - All outputs are active-high in both cases.

## Structure
- Shared package (`vlab_pkg`) holds:
  - FSM state encodings `DB_IDLE`/`DB_PRESS_WAIT`/`DB_PRESSED`/`DB_RELEASE_WAIT` (2 bits).
  - The default `DEBOUNCE_CYCLES`.
  - Channel index constants `BTN_START`/`BTN_RESET`/`BTN_2`/`BTN_1`/`BTN_0`.
- Sub-module `vdebounce_channel` handles one channel: synchroniser, counter, FSM and output registers. It takes `DEBOUNCE_CYCLES`/`CNT_WIDTH` parameters. The top module instantiates it CHANNELS times in a generate loop; the active-low inversion is applied in the top.

## Test plan
- Reset, DEBOUNCE_CYCLES=4, clean press on channel 0 held 20 cycles (raw first captured at edge 1) → `btn_level[0]` and `btn_pulse[0]` rise at edge 6; the pulse is 1 for exactly one cycle; the level stays 1 while held.
- Bounce: raw toggles 1,0,1,0 with each value held 2 cycles, then settles to 0 → no pulse, `btn_level` stays 0 throughout.
- Release bounce: from PRESSED, raw low for 3 cycles, back high for 5, then low for 10 → `btn_level` stays 1 through the glitch and falls once, with no second pulse on re-press within the glitch.
- Simultaneous: channels 4 and 1 pressed on the same edge → both pulses on the same cycle; other channels stay 0.
- Mid-operation reset: press held, `async_nreset` low at counter=2 for 3 cycles, then high with button still held → outputs 0 immediately, then one pulse at edge DEBOUNCE_CYCLES+2 after reset release.
- With `VBUTTON_ACTIVE_LOW_EN` defined: idle raw = all 1s → no pulses; raw[2] driven to 0 → `btn_pulse[2]` after the same latency.

Source files
------------

// File: rtl/vlab_pkg.sv
// Shared definitions for the vlab button-conditioning slice:
// debounce FSM state encodings, default debounce length and channel map.
package vlab_pkg;

   typedef enum logic [1:0] {
      DB_IDLE         = 2'd0,
      DB_PRESS_WAIT   = 2'd1,
      DB_PRESSED      = 2'd2,
      DB_RELEASE_WAIT = 2'd3
   } db_state_t;

   // 10 ms at 50 MHz
   localparam int unsigned LP_DEBOUNCE_CYCLES = 500000;

   // Channel map onto the reaction-game inputs
   localparam int unsigned BTN_START = 4;
   localparam int unsigned BTN_RESET = 3;
   localparam int unsigned BTN_2     = 2;
   localparam int unsigned BTN_1     = 1;
   localparam int unsigned BTN_0     = 0;

endpackage

// File: rtl/vdebounce_channel.sv
// One button channel: 2-flop synchroniser, debounce counter + FSM,
// registered level and single-cycle press pulse.
module vdebounce_channel
   import vlab_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = LP_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic async_nreset,
   input  logic i_raw,
   output logic o_level,
   output logic o_pulse
);

   localparam logic [CNT_WIDTH:0] LP_TARGET = (CNT_WIDTH + 1)'(DEBOUNCE_CYCLES);

   logic                 r_sync1;
   logic                 r_sync2;
   db_state_t            r_state;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 r_level;
   logic                 r_pulse;

   db_state_t            w_state_nxt;
   logic [CNT_WIDTH-1:0] w_cnt_nxt;
   logic                 w_pulse_nxt;
   logic                 w_level_nxt;
   logic [CNT_WIDTH:0]   w_cnt_inc;
   logic                 w_done;

   // Two-flop synchroniser, released (0) out of reset
   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
      end
   end

   // The current cycle counts towards the stable run, so a change is
   // accepted on the edge where the run reaches DEBOUNCE_CYCLES; this keeps
   // the press latency at DEBOUNCE_CYCLES+2 edges from first capture.
   assign w_cnt_inc = {1'b0, r_cnt} + (CNT_WIDTH + 1)'(1);
   assign w_done    = (w_cnt_inc == LP_TARGET);

   // Next-state, counter and pulse decode
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pulse_nxt = 1'b0;
      case (r_state)
         DB_IDLE: begin
            if (r_sync2) begin
               if (w_done) begin
                  w_state_nxt = DB_PRESSED;
                  w_cnt_nxt   = '0;
                  w_pulse_nxt = 1'b1;
               end else begin
                  w_state_nxt = DB_PRESS_WAIT;
                  w_cnt_nxt   = w_cnt_inc[CNT_WIDTH-1:0];
               end
            end
         end
         DB_PRESS_WAIT: begin
            if (!r_sync2) begin
               w_state_nxt = DB_IDLE;
               w_cnt_nxt   = '0;
            end else if (w_done) begin
               w_state_nxt = DB_PRESSED;
               w_cnt_nxt   = '0;
               w_pulse_nxt = 1'b1;
            end else begin
               w_cnt_nxt   = w_cnt_inc[CNT_WIDTH-1:0];
            end
         end
         DB_PRESSED: begin
            if (!r_sync2) begin
               if (w_done) begin
                  w_state_nxt = DB_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = DB_RELEASE_WAIT;
                  w_cnt_nxt   = w_cnt_inc[CNT_WIDTH-1:0];
               end
            end
         end
         DB_RELEASE_WAIT: begin
            if (r_sync2) begin
               w_state_nxt = DB_PRESSED;
               w_cnt_nxt   = '0;
            end else if (w_done) begin
               w_state_nxt = DB_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = w_cnt_inc[CNT_WIDTH-1:0];
            end
         end
         default: begin
            w_state_nxt = DB_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
      w_level_nxt = (w_state_nxt == DB_PRESSED) || (w_state_nxt == DB_RELEASE_WAIT);
   end

   // State, counter and registered outputs
   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         r_state <= DB_IDLE;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_pulse <= w_pulse_nxt;
      end
   end

   assign o_level = r_level;
   assign o_pulse = r_pulse;

endmodule

// File: rtl/vbutton_conditioner.sv
// Button input conditioner: one vdebounce_channel per raw button.
// Optional VBUTTON_ACTIVE_LOW_EN: invert raw buttons (board keys read 0
// when pressed) ahead of the synchronisers; outputs stay active-high.
module vbutton_conditioner
   import vlab_pkg::*;
#(
   parameter int unsigned CHANNELS        = 5,
   parameter int unsigned DEBOUNCE_CYCLES = LP_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic                clk,
   input  logic                async_nreset,
   input  logic [CHANNELS-1:0] btn_raw,
   output logic [CHANNELS-1:0] btn_level,
   output logic [CHANNELS-1:0] btn_pulse
);

   logic [CHANNELS-1:0] w_raw;

`ifdef VBUTTON_ACTIVE_LOW_EN
   assign w_raw = ~btn_raw;
`else
   assign w_raw = btn_raw;
`endif

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      vdebounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_WIDTH       (CNT_WIDTH)
      ) u_chan (
         .clk          (clk),
         .async_nreset (async_nreset),
         .i_raw        (w_raw[g]),
         .o_level      (btn_level[g]),
         .o_pulse      (btn_pulse[g])
      );
   end

endmodule

// File: tb/tb_vbutton_conditioner.sv
// Self-checking bench for vbutton_conditioner (DEBOUNCE_CYCLES=4).
// Reference model: per channel, a change is accepted once the synchronised
// input has differed from the accepted level for DEBOUNCE_CYCLES edges.
module tb_vbutton_conditioner;

   localparam int unsigned NCH = 5;
   localparam int unsigned DB  = 4;

   logic           clk;
   logic           async_nreset;
   logic [NCH-1:0] press;
   logic [NCH-1:0] btn_raw;
   logic [NCH-1:0] btn_level;
   logic [NCH-1:0] btn_pulse;

   int n_total;
   int n_bad;

   logic [NCH-1:0] m_s1, m_s2, m_lvl, m_pul;
   int             m_run [NCH];
   int             hold  [NCH];

`ifdef VBUTTON_ACTIVE_LOW_EN
   assign btn_raw = ~press;
`else
   assign btn_raw = press;
`endif

   vbutton_conditioner #(
      .CHANNELS        (NCH),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk          (clk),
      .async_nreset (async_nreset),
      .btn_raw      (btn_raw),
      .btn_level    (btn_level),
      .btn_pulse    (btn_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pul = '0;
      for (int c = 0; c < NCH; c++) m_run[c] = 0;
   endtask

   task automatic model_edge();
      if (!async_nreset) begin
         model_clear();
      end else begin
         for (int c = 0; c < NCH; c++) begin
            m_pul[c] = 1'b0;
            if (m_s2[c] != m_lvl[c]) begin
               m_run[c]++;
               if (m_run[c] == DB) begin
                  m_lvl[c] = m_s2[c];
                  m_pul[c] = m_s2[c];
                  m_run[c] = 0;
               end
            end else begin
               m_run[c] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = press;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("level", 32'(btn_level), 32'(m_lvl));
      chk("pulse", 32'(btn_pulse), 32'(m_pul));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Press (already set) first captured at edge 1: outputs rise at edge DB+2
   task automatic latency(input string tag, input logic [NCH-1:0] mask);
      for (int k = 1; k <= 8; k++) begin
         cycle();
         chk({tag, "_pulse"}, 32'(btn_pulse), (k == DB + 2) ? 32'(mask) : 32'd0);
         chk({tag, "_level"}, 32'(btn_level), (k >= DB + 2) ? 32'(mask) : 32'd0);
      end
   endtask

   initial begin
      int np, nfall, nhigh;
      logic prev;
      n_total = 0;
      n_bad   = 0;
      press   = '0;
      async_nreset = 1'b0;
      model_clear();
      #1;
      chk("rst_level", 32'(btn_level), 32'd0);
      chk("rst_pulse", 32'(btn_pulse), 32'd0);
      run(3);
      async_nreset = 1'b1;
      run(5);

      // Clean press on channel 0, held
      press[0] = 1'b1;
      latency("press0", 5'b00001);
      run(12);
      press = '0;
      run(10);

      // Bounce 1,0,1,0 (2 cycles each) then settle low
      np = 0; nhigh = 0;
      for (int j = 0; j < 4; j++) begin
         press[0] = ~j[0];
         for (int i = 0; i < 2; i++) begin
            cycle(); np += int'(btn_pulse[0]); nhigh += int'(btn_level[0]);
         end
      end
      press[0] = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cycle(); np += int'(btn_pulse[0]); nhigh += int'(btn_level[0]);
      end
      chk("bounce_pulses", 32'(np), 32'd0);
      chk("bounce_level", 32'(nhigh), 32'd0);

      // Release glitch from PRESSED
      press[0] = 1'b1;
      run(12);
      chk("rel_pre_level", 32'(btn_level[0]), 32'd1);
      np = 0; nfall = 0; prev = btn_level[0];
      for (int j = 0; j < 3; j++) begin
         press[0] = (j == 1);
         for (int i = 0; i < ((j == 0) ? 3 : (j == 1) ? 5 : 10); i++) begin
            cycle();
            np += int'(btn_pulse[0]);
            if (prev && !btn_level[0]) nfall++;
            prev = btn_level[0];
         end
      end
      chk("rel_pulses", 32'(np), 32'd0);
      chk("rel_falls", 32'(nfall), 32'd1);
      chk("rel_final", 32'(btn_level[0]), 32'd0);
      run(4);

      // Simultaneous start (4) and btn1 (1)
      press = 5'b10010;
      latency("simul", 5'b10010);
      press = '0;
      run(10);

      // Reset while counting (counter=2 after edge 4)
      press[0] = 1'b1;
      run(4);
      #2 async_nreset = 1'b0;
      model_clear();
      #1;
      chk("midrst_level", 32'(btn_level), 32'd0);
      chk("midrst_pulse", 32'(btn_pulse), 32'd0);
      run(3);
      async_nreset = 1'b1;
      latency("rstrel", 5'b00001);

      // Reset while level is high: outputs clear immediately
      #2 async_nreset = 1'b0;
      model_clear();
      #1;
      chk("hirst_level", 32'(btn_level), 32'd0);
      run(3);
      async_nreset = 1'b1;
      latency("rstrel2", 5'b00001);
      press = '0;
      run(10);

      // Randomised run lengths on all channels
      for (int c = 0; c < NCH; c++) hold[c] = $urandom_range(1, 8);
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < NCH; c++) begin
            if (hold[c] == 0) begin
               press[c] = ~press[c];
               hold[c]  = $urandom_range(1, 9);
            end else begin
               hold[c]--;
            end
         end
         cycle();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
